sm_step_monitor: RTL
====================

Name: sm_step_monitor

Overview:
- Receive side of the stepper-motor step interface: consumes the single-cycle step pulse train and a direction level, and reconstructs motion data.
- Measures the clock-cycle period between consecutive step rising edges, keeps a signed position count, and flags stalls and over-range periods.
- Sits on the 50 MHz clock domain beside the step generator; its outputs are used for closed-loop checking and diagnostics.

Parameters:
- SIZE, 16, width of the period counter and period output.
- POS_W, 32, width of the signed position counter.
- TIMEOUT, 50000, number of cycles without a step edge, while running, before stall is declared; legal range 2 .. 2^SIZE-2.
- DEGLITCH, 3, number of stable-high cycles required before an edge is accepted; used only with the optional feature.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- in_drv_enable_SM  in  1  monitor enable; low forces the IDLE state.
- step_in  in  1  step pulse from the driver, synchronous to clk.
- dir_in  in  1  direction: 1 = +1 per step, 0 = -1 per step.
- clr_pos  in  1  synchronous clear of position.
- period  out  SIZE  last measured edge-to-edge period, in cycles.
- period_valid  out  1  one-cycle strobe when period updates.
- position  out  POS_W  signed two's-complement step position.
- stall  out  1  level: no step edge for TIMEOUT cycles while running.
- overrange  out  1  one-cycle strobe: measured period saturated.

Behaviour:
- Reset values: period=0, period_valid=0, position=0, stall=0, overrange=0, state=IDLE, internal counter=0, step_d=0.
- Edge detect: edge = step_in & ~step_d, where step_d is step_in registered. All outputs are registered and update on the clock where edge=1, so they are visible 1 cycle later.
- States:
  - IDLE: entered on reset or when enable is low. Counter is held at 0 and stall=0. Position holds its value; clr_pos is still honoured. Goes to FIRST when enable=1.
  - FIRST: waits for the first edge. On edge: counter<=1, go to RUN, no period_valid.
  - RUN: counter increments each cycle and saturates at 2^SIZE-1. On edge: period<=counter, period_valid<=1, counter<=1. If counter==2^SIZE-1 at the edge, overrange<=1 as well. If counter reaches TIMEOUT with no edge: go to STALL, stall<=1.
  - STALL: stall stays high and the counter is held. On edge: stall<=0, counter<=1, go to RUN, no period_valid (the edge only re-arms).
- Period definition: rising edges on cycles t0 and t1 give period = t1 - t0.
- Position: on every edge in FIRST, RUN or STALL, position +=1 if dir_in=1, else -=1. dir_in is sampled in the edge cycle. The count wraps modulo 2^POS_W with no flag.
- clr_pos has priority: if clr_pos and edge occur in the same cycle, position<=0 and that edge's ±1 is dropped. Period and state logic still process the edge.
- Enable dropping mid-run: next state is IDLE, stall clears, and an in-flight measurement is discarded.
- rst has priority over everything else.
- A step_in held high for many cycles counts as one edge.

Optional Feature:
- Macro STEP_DEGLITCH_EN.
- Defined:
  - step_in first passes through a 2-flop synchronizer.
  - Edge detection then runs on a filtered signal. The filter goes high only after the synchronized input has been high for DEGLITCH consecutive cycles, and goes low on the first low sample.
  - Pulses shorter than DEGLITCH cycles are ignored.
  - Edge detection is delayed by 2+DEGLITCH-1 cycles; the period is unaffected for clean pulses.
- Undefined:
  - step_in feeds the edge detector directly with zero added latency.
  - DEGLITCH is unused.

Test Plan:
- Reset then enable, with 1-cycle step pulses every 100 cycles and dir_in=1 → first edge gives no period_valid. Each later edge gives period_valid with period=100. Position = 5 after 5 edges.
- Same stream with dir_in=0 for 3 edges after 5 up-edges → position=2. Then clr_pos coincident with an edge → position=0.
- TIMEOUT=200, steps stop after a run → stall=1 exactly 200 cycles after the last edge. Next edge → stall=0 with no period_valid. Edge 50 cycles later → period=50.
- SIZE=8, TIMEOUT=254, edges 254 cycles apart → period=254, overrange=0. Force saturation by holding the counter at the 255 limit (TIMEOUT=254 with a bench override, or SIZE=8, TIMEOUT=255 illegal-check) → overrange strobe, period=255.
- Enable dropped mid-run then re-raised → state FIRST, stall=0, position retained, first new edge gives no period_valid.
- With STEP_DEGLITCH_EN and DEGLITCH=3: a 2-cycle pulse → no position change. A 4-cycle pulse → position +1.

Source files
------------

// File: rtl/sm_step_monitor.sv
// sm_step_monitor: receive side of the step interface. Measures edge-to-edge period, keeps a signed
// position count and flags stalls/over-range. Define STEP_DEGLITCH_EN to add the step_in synchronizer and glitch filter.
//
// state   | meaning
// S_IDLE  | monitor disabled; counter cleared, stall low, position held
// S_FIRST | armed, waiting for the first step edge (no period yet)
// S_RUN   | counting cycles between edges, period reported on each edge
// S_STALL | no edge for TIMEOUT cycles; next edge only re-arms
module sm_step_monitor #(
    parameter int SIZE     = 16,
    parameter int POS_W    = 32,
    parameter int TIMEOUT  = 50000,
    parameter int DEGLITCH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_drv_enable_SM,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             clr_pos,
    output logic [SIZE-1:0]  period,
    output logic             period_valid,
    output logic [POS_W-1:0] position,
    output logic             stall,
    output logic             overrange
);
    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_RUN, S_STALL} state_t;

    localparam logic [SIZE-1:0]  CNT_MAX = '1;
    localparam logic [SIZE-1:0]  CNT_ONE = SIZE'(1);
    localparam logic [SIZE-1:0]  CNT_TO  = SIZE'(TIMEOUT);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    logic step_src;

`ifdef STEP_DEGLITCH_EN
    localparam int RUN_W = $clog2(DEGLITCH + 1);

    logic [1:0]       sync;
    logic [RUN_W-1:0] high_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= '0;
            high_run <= '0;
        end else begin
            sync <= {sync[0], step_in};
            if (!sync[1])
                high_run <= '0;
            else if (high_run < RUN_W'(DEGLITCH - 1))
                high_run <= high_run + 1'b1;
        end
    end

    // high_run counts earlier consecutive high samples, so this needs DEGLITCH highs including now
    assign step_src = sync[1] && (high_run >= RUN_W'(DEGLITCH - 1));
`else
    // DEGLITCH has no effect here; referenced only so both builds share one parameter set
    if (DEGLITCH < 1) begin : g_deglitch_unused
    end

    assign step_src = step_in;
`endif

    logic            step_d;
    logic            edge_det;
    state_t          state, state_nxt;
    logic [SIZE-1:0] count, count_nxt;
    logic [SIZE-1:0] period_nxt;
    logic            period_valid_nxt;
    logic            overrange_nxt;
    logic            stall_nxt;
    logic [POS_W-1:0] position_nxt;
    logic            step_counted;

    assign edge_det = step_src & ~step_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            step_d       <= 1'b0;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            overrange    <= 1'b0;
            stall        <= 1'b0;
            position     <= '0;
        end else begin
            state        <= state_nxt;
            step_d       <= step_src;
            count        <= count_nxt;
            period       <= period_nxt;
            period_valid <= period_valid_nxt;
            overrange    <= overrange_nxt;
            stall        <= stall_nxt;
            position     <= position_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!in_drv_enable_SM) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_FIRST;
                S_FIRST: if (edge_det) state_nxt = S_RUN;
                S_RUN:   if (!edge_det && count == CNT_TO) state_nxt = S_STALL;
                S_STALL: if (edge_det) state_nxt = S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        count_nxt        = count;
        period_nxt       = period;
        period_valid_nxt = 1'b0;
        overrange_nxt    = 1'b0;
        stall_nxt        = stall;
        position_nxt     = position;
        step_counted     = 1'b0;

        if (!in_drv_enable_SM) begin
            count_nxt = '0;
            stall_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    count_nxt = '0;
                    stall_nxt = 1'b0;
                end
                S_FIRST: begin
                    if (edge_det) begin
                        count_nxt    = CNT_ONE;
                        step_counted = 1'b1;
                    end
                end
                S_RUN: begin
                    // an edge on the timeout cycle still counts as a valid period
                    if (edge_det) begin
                        period_nxt       = count;
                        period_valid_nxt = 1'b1;
                        overrange_nxt    = (count == CNT_MAX);
                        count_nxt        = CNT_ONE;
                        step_counted     = 1'b1;
                    end else if (count == CNT_TO) begin
                        stall_nxt = 1'b1;
                    end else if (count != CNT_MAX) begin
                        count_nxt = count + CNT_ONE;
                    end
                end
                S_STALL: begin
                    if (edge_det) begin
                        stall_nxt    = 1'b0;
                        count_nxt    = CNT_ONE;
                        step_counted = 1'b1;
                    end
                end
                default: begin
                    count_nxt = '0;
                    stall_nxt = 1'b0;
                end
            endcase
        end

        if (clr_pos)
            position_nxt = '0;
        else if (step_counted)
            position_nxt = dir_in ? position + POS_ONE : position - POS_ONE;
    end
endmodule
